// File: rtl/axilite_pkg.sv
// Shared types for the AXI4-Lite register slave:
// response codes, ID word, FSM states, byte merge.
package axilite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam logic [31:0] ID_VALUE = 32'hA11E_0001;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axilite_regslave_if.sv
// AXI4-Lite bus bundle between a master and the
// register slave; five channels, one modport per side.
interface axilite_regslave_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] AXI_AWADDR;
  logic              AXI_AWVALID;
  logic              AXI_AWREADY;
  logic [31:0]       AXI_WDATA;
  logic [3:0]        AXI_WSTRB;
  logic              AXI_WVALID;
  logic              AXI_WREADY;
  logic [1:0]        AXI_BRESP;
  logic              AXI_BVALID;
  logic              AXI_BREADY;
  logic [ADDR_W-1:0] AXI_ARADDR;
  logic              AXI_ARVALID;
  logic              AXI_ARREADY;
  logic [31:0]       AXI_RDATA;
  logic [1:0]        AXI_RRESP;
  logic              AXI_RVALID;
  logic              AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID,
    output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    output AXI_BREADY,
    output AXI_ARADDR, AXI_ARVALID,
    output AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY,
    input  AXI_BRESP, AXI_BVALID,
    input  AXI_ARREADY,
    input  AXI_RDATA, AXI_RRESP, AXI_RVALID
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID,
    input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    input  AXI_BREADY,
    input  AXI_ARADDR, AXI_ARVALID,
    input  AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY,
    output AXI_BRESP, AXI_BVALID,
    output AXI_ARREADY,
    output AXI_RDATA, AXI_RRESP, AXI_RVALID
  );
endinterface

// File: rtl/axilite_regfile.sv
// Word register file: reg 0 is the fixed ID, the rest
// are byte-strobed R/W; read port is combinational.
module axilite_regfile
  import axilite_pkg::*;
#(
  parameter int IDX_W    = 6,
  parameter int NUM_REGS = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] regs_q [1:NUM_REGS-1];

  // Byte-strobed update of the addressed R/W word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx_i == IDX_W'(i)) begin
          regs_q[i] <= strb_merge(regs_q[i], wdata_i, wstrb_i);
        end
      end
    end
  end

  // Read mux: ID at 0, stored words above, 0 past the end
  always_comb begin
    rdata_o = '0;
    if (ridx_i == '0) rdata_o = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx_i == IDX_W'(i)) rdata_o = regs_q[i];
    end
  end

endmodule

// File: rtl/axilite_regslave.sv
// AXI4-Lite register slave: independent write and read
// FSMs in front of a small word register file.
module axilite_regslave
  import axilite_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic AXI_ACLK,
  input  logic AXI_ARESETN,
  axilite_regslave_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);

  function automatic logic idx_ok(input logic [IDX_W-1:0] i);
    return {1'b0, i} < NREG;
  endfunction

  wstate_t ws_q, ws_d;
  rstate_t rs_q, rs_d;
  logic up_q;

  logic [IDX_W-1:0]  aidx_q, aidx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  resp_t             bresp_q, bresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs;
  logic have_a, have_d, commit, wok, we;
  logic [IDX_W-1:0]  aw_idx, ridx, cidx;
  logic [DATA_W-1:0] cdata;
  logic [3:0]        cstrb;
  logic [31:0]       rf_rdata;
  logic              unused_lsb;

  assign unused_lsb = ^{bus.AXI_AWADDR[1:0],
                        bus.AXI_ARADDR[1:0]};

  assign awready = up_q && (ws_q == W_IDLE ||
                            ws_q == W_HAVE_DATA);
  assign wready  = up_q && (ws_q == W_IDLE ||
                            ws_q == W_HAVE_ADDR);
  assign arready = up_q && (rs_q == R_IDLE);

  assign aw_hs = bus.AXI_AWVALID && awready;
  assign w_hs  = bus.AXI_WVALID && wready;
  assign ar_hs = bus.AXI_ARVALID && arready;

  assign aw_idx = bus.AXI_AWADDR[ADDR_W-1:2];
  assign ridx   = bus.AXI_ARADDR[ADDR_W-1:2];

  assign have_a = (ws_q == W_HAVE_ADDR) || aw_hs;
  assign have_d = (ws_q == W_HAVE_DATA) || w_hs;
  assign commit = have_a && have_d;

  assign cidx  = (ws_q == W_HAVE_ADDR) ? aidx_q : aw_idx;
  assign cdata = (ws_q == W_HAVE_DATA) ? wdata_q
                                       : bus.AXI_WDATA;
  assign cstrb = (ws_q == W_HAVE_DATA) ? wstrb_q
                                       : bus.AXI_WSTRB;
  assign wok   = (cidx != '0) && idx_ok(cidx);
  assign we    = commit && wok;

  // Write FSM: gather AW and W in any order, then respond
  always_comb begin
    ws_d    = ws_q;
    aidx_d  = aidx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    unique case (ws_q)
      W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
        if (commit) begin
          ws_d    = W_RESP;
          aidx_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          bresp_d = wok ? OKAY : SLVERR;
        end else if (aw_hs) begin
          ws_d   = W_HAVE_ADDR;
          aidx_d = aw_idx;
        end else if (w_hs) begin
          ws_d    = W_HAVE_DATA;
          wdata_d = bus.AXI_WDATA;
          wstrb_d = bus.AXI_WSTRB;
        end
      end
      W_RESP: begin
        if (bus.AXI_BREADY) ws_d = W_IDLE;
      end
    endcase
  end

  // Read FSM: capture data at AR handshake, hold until R
  always_comb begin
    rs_d    = rs_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rs_q)
      R_IDLE: begin
        if (ar_hs) begin
          rs_d = R_RESP;
          if (idx_ok(ridx)) begin
            rdata_d = rf_rdata;
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
        end
      end
      R_RESP: begin
        if (bus.AXI_RREADY) rs_d = R_IDLE;
      end
    endcase
  end

  // State and holding registers; up_q gates READY out of reset
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      up_q    <= 1'b0;
      ws_q    <= W_IDLE;
      rs_q    <= R_IDLE;
      aidx_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= OKAY;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      up_q    <= 1'b1;
      ws_q    <= ws_d;
      rs_q    <= rs_d;
      aidx_q  <= aidx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  axilite_regfile #(
    .IDX_W   (IDX_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk_i  (AXI_ACLK),
    .rst_ni (AXI_ARESETN),
    .we_i   (we),
    .widx_i (cidx),
    .wdata_i(cdata),
    .wstrb_i(cstrb),
    .ridx_i (ridx),
    .rdata_o(rf_rdata)
  );

  assign bus.AXI_AWREADY = awready;
  assign bus.AXI_WREADY  = wready;
  assign bus.AXI_ARREADY = arready;
  assign bus.AXI_BVALID  = (ws_q == W_RESP);
  assign bus.AXI_BRESP   = bresp_q;
  assign bus.AXI_RVALID  = (rs_q == R_RESP);
  assign bus.AXI_RRESP   = rresp_q;
  assign bus.AXI_RDATA   = rdata_q;

endmodule
